// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU issue/writeback stage.
package alu_pkg;

  localparam int W     = 12;
  localparam int NREGS = 8;
  localparam int RW    = $clog2(NREGS);

  typedef enum logic [2:0] {
    OP_LOADI = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_UMUL  = 3'd3,
    OP_SMUL  = 3'd4,
    OP_FADD  = 3'd5,
    OP_FMUL  = 3'd6,
    OP_CMP   = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t       op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [W-1:0]  imm;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, three asynchronous reads
// (two operand ports and a debug port).
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [W-1:0]             rdata1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [W-1:0]             rdata2,
  input  logic [$clog2(NREGS)-1:0] raddr3,
  output logic [W-1:0]             rdata3
);

  logic [W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
  assign rdata3 = mem[raddr3];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue + writeback stage around a combinational 12-bit ALU.
// ALU_ISSUE_FORWARD_EN: forward EX result to operands instead of stalling.
module alu_issue_unit #(
  parameter int NREGS = 8,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [2:0]               instr_op,
  input  logic [$clog2(NREGS)-1:0] instr_rd,
  input  logic [$clog2(NREGS)-1:0] instr_rs1,
  input  logic [$clog2(NREGS)-1:0] instr_rs2,
  input  logic [W-1:0]             instr_imm,
  output logic [2:0]               alu_opcode,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  input  logic [W-1:0]             alu_result,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [W-1:0]             wb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [W-1:0]             dbg_data
);

  import alu_pkg::*;

  localparam int RW = $clog2(NREGS);

  instr_t        in;
  logic          ex_valid;
  opcode_t       ex_op;
  logic [RW-1:0] ex_rd;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [W-1:0]  ex_imm;
  logic [W-1:0]  ex_res;
  logic [W-1:0]  rd1;
  logic [W-1:0]  rd2;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          hit1;
  logic          hit2;
  logic          accept;

  always_comb begin
    in     = '0;
    in.op  = opcode_t'(instr_op);
    in.rd  = instr_rd;
    in.rs1 = instr_rs1;
    in.rs2 = instr_rs2;
    in.imm = instr_imm;
  end

  assign ex_res = (ex_op == OP_LOADI) ? ex_imm : alu_result;
  assign hit1   = ex_valid && (ex_rd == in.rs1);
  assign hit2   = ex_valid && (ex_rd == in.rs2);

`ifdef ALU_ISSUE_FORWARD_EN
  assign instr_ready = rst_n;
  assign op_a        = hit1 ? ex_res : rd1;
  assign op_b        = hit2 ? ex_res : rd2;
`else
  // one bubble lets the in-flight result land in the register file
  logic hazard;
  assign hazard      = (in.op != OP_LOADI) && (hit1 || hit2);
  assign instr_ready = rst_n && !hazard;
  assign op_a        = rd1;
  assign op_b        = rd2;
`endif

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_LOADI;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_op  <= in.op;
        ex_rd  <= in.rd;
        ex_a   <= op_a;
        ex_b   <= op_b;
        ex_imm <= in.imm;
      end
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd   <= ex_rd;
        wb_data <= ex_res;
      end
    end
  end

  assign alu_opcode = ex_op;
  assign alu_a      = ex_a;
  assign alu_b      = ex_b;

  alu_regfile #(
    .NREGS (NREGS),
    .W     (W)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (ex_valid),
    .waddr  (ex_rd),
    .wdata  (ex_res),
    .raddr1 (in.rs1),
    .rdata1 (rd1),
    .raddr2 (in.rs2),
    .rdata2 (rd2),
    .raddr3 (dbg_addr),
    .rdata3 (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: program-order reference model plus directed
// literal checks from the test plan, then randomized traffic.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = '0;
  logic [2:0]  instr_rd = '0;
  logic [2:0]  instr_rs1 = '0;
  logic [2:0]  instr_rs2 = '0;
  logic [11:0] instr_imm = '0;
  logic [2:0]  alu_opcode;
  logic [11:0] alu_a;
  logic [11:0] alu_b;
  logic [11:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [11:0] wb_data;
  logic [2:0]  dbg_addr = '0;
  logic [11:0] dbg_data;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

`ifdef ALU_ISSUE_FORWARD_EN
  localparam int ADD_STALLS = 0;
`else
  localparam int ADD_STALLS = 1;
`endif

  always #5 clk = ~clk;

  alu_issue_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // ALU stand-in; FADD/FMUL are arbitrary but deterministic
  function automatic logic [11:0] alu_f(input logic [2:0] op,
                                        input logic [11:0] a,
                                        input logic [11:0] b);
    logic [23:0] p;
    logic signed [23:0] sp;
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: begin p = a * b; return p[11:0]; end
      3'd4: begin sp = $signed(a) * $signed(b); return sp[11:0]; end
      3'd5: return a ^ b;
      3'd6: return a & b;
      3'd7: begin
        if (a == b) return 12'h000;
        else if ($signed(a) < $signed(b)) return 12'hFFF;
        else return 12'h001;
      end
      default: return 12'h000;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

  // Reference: arch[] is the program-order register state (updated at
  // accept), com[] is what the register file holds (updated at writeback).
  logic [11:0] arch [8];
  logic [11:0] com  [8];
  logic        m_valid = 1'b0;
  logic [2:0]  m_op = '0;
  logic [2:0]  m_rd = '0;
  logic [11:0] m_a = '0;
  logic [11:0] m_b = '0;
  logic [11:0] m_res = '0;
  logic        e_wbv = 1'b0;
  logic [2:0]  e_wbrd = '0;
  logic [11:0] e_wbd = '0;
  bit          last_acc = 1'b0;

  function automatic logic exp_ready();
    if (!rst_n) return 1'b0;
`ifdef ALU_ISSUE_FORWARD_EN
    return 1'b1;
`else
    return !(m_valid && instr_op != 3'd0 &&
             (m_rd == instr_rs1 || m_rd == instr_rs2));
`endif
  endfunction

  task automatic model_step();
    logic acc;
    logic [11:0] a;
    logic [11:0] b;
    acc = instr_valid && exp_ready();
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        arch[i] = '0;
        com[i]  = '0;
      end
      m_valid = 1'b0;
      m_op = '0;
      m_rd = '0;
      m_a = '0;
      m_b = '0;
      m_res = '0;
      e_wbv = 1'b0;
      e_wbrd = '0;
      e_wbd = '0;
      acc = 1'b0;
    end else begin
      e_wbv = m_valid;
      if (m_valid) begin
        com[m_rd] = m_res;
        e_wbrd = m_rd;
        e_wbd = m_res;
      end
      if (acc) begin
        a = arch[instr_rs1];
        b = arch[instr_rs2];
        m_op = instr_op;
        m_rd = instr_rd;
        m_a = a;
        m_b = b;
        m_res = (instr_op == 3'd0) ? instr_imm : alu_f(instr_op, a, b);
        arch[instr_rd] = m_res;
      end
      m_valid = acc;
    end
    last_acc = acc;
  endtask

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    chk("instr_ready", {11'b0, instr_ready}, {11'b0, exp_ready()});
    chk("wb_valid", {11'b0, wb_valid}, {11'b0, e_wbv});
    chk("wb_rd", {9'b0, wb_rd}, {9'b0, e_wbrd});
    chk("wb_data", wb_data, e_wbd);
    chk("alu_opcode", {9'b0, alu_opcode}, {9'b0, m_op});
    if (m_valid && m_op != 3'd0) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
    end
    chk("dbg_data", dbg_data, com[dbg_addr]);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) mon_step();
  end

  // call 1 time unit after a rising edge; returns likewise after accept
  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [11:0] imm, output int stalls);
    bit r;
    bit done;
    done = 1'b0;
    stalls = 0;
    instr_valid = 1'b1;
    instr_op = op;
    instr_rd = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
    instr_imm = imm;
    for (int k = 0; k < 6 && !done; k++) begin
      @(negedge clk);
      r = instr_ready;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue: op %0d rd %0d not accepted", op, rd);
    end
    instr_valid = 1'b0;
  endtask

  task automatic wait_wb(input logic [2:0] rd, input logic [11:0] d,
                         input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (wb_valid && wb_rd == rd) begin
        found = 1'b1;
        chk(nm, wb_data, d);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: no writeback to r%0d", nm, rd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    rst_n = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst instr_ready", {11'b0, instr_ready}, 12'h000);
    chk("rst wb_valid", {11'b0, wb_valid}, 12'h000);
    chk("rst wb_rd", {9'b0, wb_rd}, 12'h000);
    chk("rst wb_data", wb_data, 12'h000);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("rst dbg", dbg_data, 12'h000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(3'd0, 3'd1, 3'd0, 3'd0, 12'h0DF, s);
    issue(3'd0, 3'd2, 3'd0, 3'd0, 12'h0B6, s);
    issue(3'd1, 3'd3, 3'd1, 3'd2, 12'h000, s);
    chk("add stalls", 12'(s), 12'(ADD_STALLS));
    @(negedge clk);
    chk("add opcode", {9'b0, alu_opcode}, 12'h001);
    chk("add alu_a", alu_a, 12'h0DF);
    chk("add alu_b", alu_b, 12'h0B6);
    wait_wb(3'd3, 12'h195, "add wb_data");

    issue(3'd2, 3'd4, 3'd1, 3'd2, 12'h000, s);
    wait_wb(3'd4, 12'h029, "sub wb_data");

    issue(3'd0, 3'd5, 3'd0, 3'd0, 12'h007, s);
    issue(3'd0, 3'd6, 3'd0, 3'd0, 12'hFFB, s);
    issue(3'd4, 3'd7, 3'd5, 3'd6, 12'h000, s);
    dbg_addr = 3'd7;
    @(negedge clk);
    chk("r7 before write", dbg_data, 12'h000);
    wait_wb(3'd7, 12'hFDD, "smul wb_data");
    chk("r7 after write", dbg_data, 12'hFDD);

    issue(3'd0, 3'd1, 3'd0, 3'd0, 12'h160, s);
    issue(3'd0, 3'd2, 3'd0, 3'd0, 12'h160, s);
    issue(3'd7, 3'd0, 3'd1, 3'd2, 12'h000, s);
    wait_wb(3'd0, 12'h000, "cmp wb_data");

    issue(3'd1, 3'd5, 3'd1, 3'd2, 12'h000, s);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst wb_valid", {11'b0, wb_valid}, 12'h000);
    dbg_addr = 3'd5;
    #1;
    chk("midrst r5", dbg_data, 12'h000);
    @(posedge clk);
    #1;

    for (int c = 0; c < 600; c++) begin
      if (!instr_valid || last_acc) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        instr_op = 3'($urandom_range(0, 7));
        instr_rd = 3'($urandom_range(0, 7));
        instr_rs1 = 3'($urandom_range(0, 7));
        instr_rs2 = 3'($urandom_range(0, 7));
        instr_imm = 12'($urandom);
      end
      dbg_addr = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 63) != 0);
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
